// File: rtl/axi_ic_pkg.sv
// Shared types, slice mode codes and the round-robin pick helper for the AXI interconnect.
package axi_ic_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  localparam int SLICE_BYPASS = 0;
  localparam int SLICE_FWD    = 1;
  localparam int SLICE_BWD    = 2;
  localparam int SLICE_FULL   = 3;

  localparam int RR_MAX = 16;

  // First set bit of req at or above ptr, wrapping at nr; returns ptr when req is empty.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req, input logic [3:0] ptr,
                                         input int nr);
    logic [3:0] win;
    logic [3:0] idx;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = 4'((int'(ptr) + i) % nr);
      if (!found && (i < nr) && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axi_skidbuffer.sv
// Valid/ready register slice: bypass, forward (+1 cycle valid), backward (registered in_rdy) or both.
// Backpressure: a backward stage parks one beat while stalled; a forward stage holds its beat until out_rdy.
module axi_skidbuffer
  import axi_ic_pkg::*;
#(
  parameter int DW   = 8,
  parameter int MODE = SLICE_FULL
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat
);

  logic          mid_vld;
  logic          mid_rdy;
  logic [DW-1:0] mid_dat;

  generate
    if (MODE == SLICE_BWD || MODE == SLICE_FULL) begin : g_bwd
      logic          skid_vld;
      logic [DW-1:0] skid_dat;

      always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
          skid_vld <= 1'b0;
          skid_dat <= '0;
        end else if (skid_vld) begin
          if (mid_rdy) skid_vld <= 1'b0;
        end else if (in_vld && !mid_rdy) begin
          skid_vld <= 1'b1;
          skid_dat <= in_dat;
        end
      end

      assign in_rdy  = !skid_vld;
      assign mid_vld = skid_vld || in_vld;
      assign mid_dat = skid_vld ? skid_dat : in_dat;
    end else begin : g_bwd_thru
      assign in_rdy  = mid_rdy;
      assign mid_vld = in_vld;
      assign mid_dat = in_dat;
    end

    if (MODE == SLICE_FWD || MODE == SLICE_FULL) begin : g_fwd
      logic          vld_q;
      logic [DW-1:0] dat_q;

      always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else if (mid_rdy) begin
          vld_q <= mid_vld;
          if (mid_vld) dat_q <= mid_dat;
        end
      end

      assign mid_rdy = !vld_q || out_rdy;
      assign out_vld = vld_q;
      assign out_dat = dat_q;
    end else begin : g_fwd_thru
      assign mid_rdy = out_rdy;
      assign out_vld = mid_vld;
      assign out_dat = mid_dat;
    end
  endgenerate

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-to-1 round-robin arbiter holding each grant for a whole packet; 1 arbitration cycle plus slice latency.
// Backpressure: only the granted s_ready follows the slice ready, never any s_valid.
module axi_rr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int NR   = 4,
  parameter int DW   = 8,
  parameter int MODE = SLICE_FWD,
  parameter int IDW  = $clog2(NR)
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [NR*DW-1:0] s_data,
  input  logic [NR-1:0]    s_last,
  input  logic [NR-1:0]    s_valid,
  output logic [NR-1:0]    s_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  output logic [IDW-1:0]   m_id,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int SW = DW + IDW + 1;

  arb_state_t        state, state_nxt;
  logic [IDW-1:0]    grant, grant_nxt;
  logic [IDW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [RR_MAX-1:0] req;
  logic [DW-1:0]     sel_data;
  logic              sel_last;
  logic              sel_valid;
  logic              arb_valid;
  logic              arb_ready;
  logic              arb_last;
  logic [DW-1:0]     arb_data;
  logic [SW-1:0]     arb_pkt;
  logic [SW-1:0]     out_pkt;

  assign req = RR_MAX'(s_valid);

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (grant == IDW'(k)) begin
        sel_data  = s_data[k*DW +: DW];
        sel_last  = s_last[k];
        sel_valid = s_valid[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // The pointer only advances on a completed packet, so a dropped partial packet keeps its priority.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (|s_valid) begin
          state_nxt = ARB_LOCK;
          grant_nxt = IDW'(rr_pick(req, 4'(rr_ptr), NR));
        end
      end
      ARB_LOCK: begin
        if (sel_valid && arb_ready && sel_last) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = (grant == IDW'(NR - 1)) ? '0 : grant + IDW'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    arb_valid = 1'b0;
    arb_data  = '0;
    arb_last  = 1'b0;
    s_ready   = '0;
    if (state == ARB_LOCK) begin
      arb_valid = sel_valid;
      arb_data  = sel_data;
      arb_last  = sel_last;
      for (int k = 0; k < NR; k++) begin
        if (grant == IDW'(k)) s_ready[k] = arb_ready;
      end
    end
  end

  assign arb_pkt = {grant, arb_last, arb_data};

  generate
    if (MODE == SLICE_BYPASS) begin : g_bypass
      assign out_pkt   = arb_pkt;
      assign m_valid   = arb_valid;
      assign arb_ready = m_ready;
    end else begin : g_slice
      axi_skidbuffer #(
        .DW   (SW),
        .MODE (MODE)
      ) u_slice (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .in_vld   (arb_valid),
        .in_rdy   (arb_ready),
        .in_dat   (arb_pkt),
        .out_vld  (m_valid),
        .out_rdy  (m_ready),
        .out_dat  (out_pkt)
      );
    end
  endgenerate

  assign {m_id, m_last, m_data} = out_pkt;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: a MODE 1 and a MODE 3 instance share stimulus, one is observed at a time.
module tb_axi_rr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;

  typedef struct packed {
    logic [7:0] gap;
    logic       last;
    logic [7:0] dat;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic [NR*DW-1:0] s_data;
  logic [NR-1:0]    s_last;
  logic [NR-1:0]    s_valid;
  logic             m_ready;
  logic [NR-1:0]    s_ready1, s_ready3;
  logic [DW-1:0]    m_data1, m_data3;
  logic             m_last1, m_last3;
  logic [IDW-1:0]   m_id1, m_id3;
  logic             m_valid1, m_valid3;

  beat_t      q[NR][$];
  logic [8:0] expq[NR][$];
  int         rx_id[$], rx_dat[$], rx_lst[$], rx_cyc[$];
  int         hs_cnt[NR];
  int         n_chk, n_bad, cyc, c0;
  logic       use3, bp, stalled;
  logic [11:0] held;

  axi_rr_arbiter #(.NR(NR), .DW(DW), .MODE(1)) u_dut1 (
    .i_clk(clk), .i_resetn(rst_n), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready1), .m_data(m_data1), .m_last(m_last1), .m_id(m_id1),
    .m_valid(m_valid1), .m_ready(m_ready));

  axi_rr_arbiter #(.NR(NR), .DW(DW), .MODE(3)) u_dut3 (
    .i_clk(clk), .i_resetn(rst_n), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready3), .m_data(m_data3), .m_last(m_last3), .m_id(m_id3),
    .m_valid(m_valid3), .m_ready(m_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < NR; k++) begin
      s_valid[k]          = 1'b0;
      s_last[k]           = 1'b0;
      s_data[k*DW +: DW]  = '0;
      if (q[k].size() > 0) begin
        b = q[k][0];
        if (b.gap != 0) begin
          b.gap   = b.gap - 8'd1;
          q[k][0] = b;
        end else begin
          s_valid[k]         = 1'b1;
          s_last[k]          = b.last;
          s_data[k*DW +: DW] = b.dat;
        end
      end
    end
  endtask

  task automatic add_pkt(input int k, input int len, input int base, input int gidx, input int glen);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.dat  = 8'(base + j);
      b.last = (j == len - 1);
      b.gap  = (j == gidx) ? 8'(glen) : 8'd0;
      q[k].push_back(b);
      expq[k].push_back({b.last, b.dat});
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NR; k++) begin
      q[k].delete();
      expq[k].delete();
    end
    rx_id.delete(); rx_dat.delete(); rx_lst.delete(); rx_cyc.delete();
    stalled = 1'b0;
    drive();
  endtask

  // Sample at the falling edge, then advance the sources after the rising edge.
  task automatic tick();
    logic [NR-1:0] hs;
    logic          mv, ml;
    logic [7:0]    md;
    logic [1:0]    mi;
    @(negedge clk);
    hs = s_valid & (use3 ? s_ready3 : s_ready1);
    mv = use3 ? m_valid3 : m_valid1;
    ml = use3 ? m_last3 : m_last1;
    md = use3 ? m_data3 : m_data1;
    mi = use3 ? m_id3 : m_id1;
    if (stalled) chk("stable", {mv, mi, ml, md}, held);
    if (mv && m_ready) begin
      rx_id.push_back(int'(mi));
      rx_dat.push_back(int'(md));
      rx_lst.push_back(int'(ml));
      rx_cyc.push_back(cyc);
    end
    stalled = mv && !m_ready;
    held    = {mv, mi, ml, md};
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NR; k++) begin
      if (hs[k]) begin
        void'(q[k].pop_front());
        hs_cnt[k]++;
      end
    end
    if (bp) m_ready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (rx_id.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk(tag, rx_id.size(), n);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_bp();
    int         id;
    logic [8:0] e;
    for (int i = 0; i < rx_id.size(); i++) begin
      id = rx_id[i];
      chk($sformatf("bp_have%0d", i), expq[id].size() > 0, 1);
      if (expq[id].size() > 0) begin
        e = expq[id].pop_front();
        chk($sformatf("bp_dat%0d", i), rx_dat[i], e[7:0]);
        chk($sformatf("bp_lst%0d", i), rx_lst[i], e[8]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0;
    use3 = 1'b0; bp = 1'b0; stalled = 1'b0; held = '0;
    for (int k = 0; k < NR; k++) hs_cnt[k] = 0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    clear_all();
    #12;
    chk("rst_sready1", s_ready1, 0);
    chk("rst_mvalid1", m_valid1, 0);
    chk("rst_mdata1", m_data1, 0);
    chk("rst_mlast1", m_last1, 0);
    chk("rst_mid1", m_id1, 0);
    chk("rst_sready3", s_ready3, 0);
    chk("rst_mvalid3", m_valid3, 0);
    chk("rst_mdata3", m_data3, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Fairness: all four hold single-beat packets, pointer starts at 0.
    for (int k = 0; k < NR; k++) add_pkt(k, 1, 16 * k, -1, 0);
    for (int k = 0; k < NR; k++) add_pkt(k, 1, 16 * k + 1, -1, 0);
    for (int k = 0; k < NR; k++) add_pkt(k, 1, 16 * k + 2, -1, 0);
    drive();
    c0 = cyc;
    wait_rx("fair_cnt", 12, 60);
    chk("fair_lat", rx_cyc[0] - c0, 2);
    for (int i = 0; i < 6; i++) chk($sformatf("fair_id%0d", i), rx_id[i], i % 4);
    for (int i = 1; i < 6; i++) chk($sformatf("fair_gap%0d", i), rx_cyc[i] - rx_cyc[i-1], 2);
    chk("fair_dat4", rx_dat[4], 8'h01);

    // Single requester 2, three beats.
    clear_all();
    add_pkt(2, 3, 8'hA1, -1, 0);
    drive();
    c0 = cyc;
    wait_rx("one_cnt", 3, 20);
    chk("one_lat", rx_cyc[0] - c0, 2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("one_id%0d", i), rx_id[i], 2);
      chk($sformatf("one_dat%0d", i), rx_dat[i], 8'hA1 + i);
      chk($sformatf("one_lst%0d", i), rx_lst[i], (i == 2) ? 1 : 0);
    end

    // Wrap: pointer is 3, requesters 0 and 3 both pending.
    clear_all();
    add_pkt(0, 1, 8'h50, -1, 0);
    add_pkt(3, 1, 8'h53, -1, 0);
    drive();
    wait_rx("wrap_cnt", 2, 20);
    chk("wrap_id0", rx_id[0], 3);
    chk("wrap_id1", rx_id[1], 0);
    clear_all();
    add_pkt(0, 1, 8'h60, -1, 0);
    add_pkt(1, 1, 8'h61, -1, 0);
    drive();
    wait_rx("ptr_cnt", 2, 20);
    chk("ptr1_id0", rx_id[0], 1);
    chk("ptr1_id1", rx_id[1], 0);

    // Lock hold: requester 1 pauses 3 cycles mid-packet while requester 0 waits.
    clear_all();
    add_pkt(1, 4, 8'hB1, 2, 3);
    add_pkt(0, 1, 8'hC0, -1, 0);
    drive();
    wait_rx("lock_cnt", 5, 40);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lock_id%0d", i), rx_id[i], (i < 4) ? 1 : 0);
      chk($sformatf("lock_dat%0d", i), rx_dat[i], (i < 4) ? 8'hB1 + i : 8'hC0);
    end
    chk("lock_lst3", rx_lst[3], 1);
    chk("lock_gap", rx_cyc[2] - rx_cyc[1], 4);

    // Backpressure on the fully registered instance.
    use3 = 1'b1;
    reset_pulse();
    bp = 1'b1;
    add_pkt(0, 3, 8'h00, -1, 0); add_pkt(0, 2, 8'h08, -1, 0);
    add_pkt(1, 4, 8'h10, -1, 0); add_pkt(1, 1, 8'h18, -1, 0);
    add_pkt(2, 2, 8'h20, -1, 0); add_pkt(2, 3, 8'h28, -1, 0);
    add_pkt(3, 1, 8'h30, -1, 0); add_pkt(3, 4, 8'h38, -1, 0);
    drive();
    wait_rx("bp_cnt", 20, 600);
    repeat (10) tick();
    chk("bp_nodup", rx_id.size(), 20);
    check_bp();
    bp = 1'b0;
    m_ready = 1'b1;
    use3 = 1'b0;

    // Reset mid-packet with the pointer parked at 3.
    reset_pulse();
    add_pkt(2, 1, 8'h70, -1, 0);
    drive();
    wait_rx("pre_cnt", 1, 20);
    add_pkt(1, 3, 8'h80, -1, 0);
    drive();
    c0 = hs_cnt[1];
    for (int t = 0; t < 20 && hs_cnt[1] == c0; t++) tick();
    chk("mid_beat1", hs_cnt[1] - c0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_mvalid", m_valid1, 0);
    chk("mid_sready", s_ready1, 0);
    chk("mid_mid", m_id1, 0);
    clear_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_pkt(0, 1, 8'h90, -1, 0);
    add_pkt(3, 1, 8'h93, -1, 0);
    drive();
    wait_rx("post_cnt", 2, 20);
    chk("post_id0", rx_id[0], 0);
    chk("post_id1", rx_id[1], 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
